mem_bus_arbiter: RTL and testbench

- Arbitrates the single-port program/data RAM between two requesters: the CPU control block and the external program loader/debug port on the uio pins.
- Sits between the control block's memory-access control signals, the loader interface, and the RAM.
- Grants one transfer at a time and inserts a turnaround cycle on every owner change.
- Bounds loader hold time so the CPU cannot starve.

---
 rtl/mem_bus_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-requester (CPU / loader) arbiter for a single-port RAM.
// One transfer at a time (IDLE -> [TURN] -> ACC -> RESP), a turnaround cycle on
// every owner change, and a bounded loader hold so the CPU cannot starve.
// Optional build macro: ARB_LOCK_EN (honour ldr_lock as a loader bus lock).
module mem_bus_arbiter #(
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_wait,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_ack,
    output logic [DATA_W-1:0] ldr_rdata,
    input  logic              ldr_lock,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        owner
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_TURN = 2'd1;
    localparam logic [1:0] S_ACC  = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_CPU  = 2'b01;
    localparam logic [1:0] OWN_LDR  = 2'b10;

    localparam logic [3:0] LP_MAX_HOLD = 4'(MAX_HOLD);

    logic [1:0]        r_state;
    logic [3:0]        r_hold;
    logic              r_sel_ldr;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic              w_lock;
    logic              w_hold_full;
    logic              w_grant_cpu;
    logic              w_grant_ldr;
    logic              w_any;
    logic              w_direct;
    logic [1:0]        w_win_code;
    logic              w_req_we;
    logic [ADDR_W-1:0] w_req_addr;
    logic [DATA_W-1:0] w_req_wdata;

`ifdef ARB_LOCK_EN
    assign w_lock = ldr_lock & (owner == OWN_LDR);
`else
    logic w_unused_lock;
    assign w_unused_lock = ldr_lock;
    assign w_lock        = 1'b0;
`endif

    assign w_hold_full = (r_hold == LP_MAX_HOLD);
    assign cpu_wait    = cpu_req & ~cpu_ack;

    // Winner selection from the sampled requests; the lock blocks any CPU grant.
    always_comb begin
        w_grant_cpu = 1'b0;
        w_grant_ldr = 1'b0;
        if (ldr_req && !(cpu_req && w_hold_full && !w_lock)) begin
            w_grant_ldr = 1'b1;
        end else if (cpu_req && !w_lock) begin
            w_grant_cpu = 1'b1;
        end
    end

    assign w_any       = w_grant_cpu | w_grant_ldr;
    assign w_win_code  = w_grant_ldr ? OWN_LDR : OWN_CPU;
    assign w_direct    = (owner == OWN_NONE) || (owner == w_win_code);
    assign w_req_we    = w_grant_ldr ? ldr_we    : cpu_we;
    assign w_req_addr  = w_grant_ldr ? ldr_addr  : cpu_addr;
    assign w_req_wdata = w_grant_ldr ? ldr_wdata : cpu_wdata;

    // Transfer sequencer: latches the winning request and drives the RAM/ack registers.
    // A direct grant loads the RAM registers straight from the request so ACC follows IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            owner     <= OWN_NONE;
            r_sel_ldr <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            cpu_ack   <= 1'b0;
            ldr_ack   <= 1'b0;
            cpu_rdata <= '0;
            ldr_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        owner     <= w_win_code;
                        r_sel_ldr <= w_grant_ldr;
                        r_we      <= w_req_we;
                        r_addr    <= w_req_addr;
                        r_wdata   <= w_req_wdata;
                        if (w_direct) begin
                            r_state   <= S_ACC;
                            mem_addr  <= w_req_addr;
                            mem_wdata <= w_req_wdata;
                            mem_we    <= w_req_we;
                            mem_re    <= ~w_req_we;
                        end else begin
                            r_state <= S_TURN;
                        end
                    end
                end
                S_TURN: begin
                    r_state   <= S_ACC;
                    mem_addr  <= r_addr;
                    mem_wdata <= r_wdata;
                    mem_we    <= r_we;
                    mem_re    <= ~r_we;
                end
                S_ACC: begin
                    r_state <= S_RESP;
                    mem_we  <= 1'b0;
                    mem_re  <= 1'b0;
                    if (r_sel_ldr) begin
                        ldr_ack <= 1'b1;
                        if (!r_we) begin
                            ldr_rdata <= mem_rdata;
                        end
                    end else begin
                        cpu_ack <= 1'b1;
                        if (!r_we) begin
                            cpu_rdata <= mem_rdata;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    cpu_ack <= 1'b0;
                    ldr_ack <= 1'b0;
                end
            endcase
        end
    end

    // Loader hold counter: counts loader grants made against a waiting CPU.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_grant_cpu || !cpu_req) begin
                r_hold <= '0;
            end else if (w_grant_ldr && !w_hold_full) begin
                r_hold <= r_hold + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed self-checking bench for mem_bus_arbiter with a
// small combinational-read RAM model attached to the mem_* port.
module tb_mem_bus_arbiter;

    logic       clk;
    logic       rst;
    logic       cpu_req, cpu_we, cpu_ack, cpu_wait;
    logic [3:0] cpu_addr;
    logic [7:0] cpu_wdata, cpu_rdata;
    logic       ldr_req, ldr_we, ldr_ack, ldr_lock;
    logic [3:0] ldr_addr;
    logic [7:0] ldr_wdata, ldr_rdata;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;
    logic       mem_we, mem_re;
    logic [1:0] owner;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] ram [16] = '{8'h00, 8'h01, 8'h02, 8'hA5, 8'h04, 8'h05, 8'h06, 8'h07,
                             8'h08, 8'h11, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F};

    mem_bus_arbiter #(
        .ADDR_W  (4),
        .DATA_W  (8),
        .MAX_HOLD(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_ack  (cpu_ack),
        .cpu_rdata(cpu_rdata),
        .cpu_wait (cpu_wait),
        .ldr_req  (ldr_req),
        .ldr_we   (ldr_we),
        .ldr_addr (ldr_addr),
        .ldr_wdata(ldr_wdata),
        .ldr_ack  (ldr_ack),
        .ldr_rdata(ldr_rdata),
        .ldr_lock (ldr_lock),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we   (mem_we),
        .mem_re   (mem_re),
        .mem_rdata(mem_rdata),
        .owner    (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = ram[mem_addr];

    // RAM model write port.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        ldr_req = 0; ldr_we = 0; ldr_addr = '0; ldr_wdata = '0; ldr_lock = 0;
        repeat (2) tick();
        tests_run++;
        if ({owner, mem_we, mem_re, mem_addr, mem_wdata, cpu_ack, ldr_ack, cpu_rdata, ldr_rdata} !== 36'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got owner=%b we=%b re=%b addr=%h wd=%h cack=%b lack=%b crd=%h lrd=%h, want all 0",
                     owner, mem_we, mem_re, mem_addr, mem_wdata, cpu_ack, ldr_ack, cpu_rdata, ldr_rdata);
        end
        rst = 1'b0;
        tick();
        tests_run++;
        if (mem_re !== 1'b0 || owner !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_idle: got re=%b owner=%b, want 0 00", mem_re, owner);
        end
    endtask

    task automatic test_cpu_read();
        cpu_req = 1; cpu_we = 0; cpu_addr = 4'h3;
        tick();
        tests_run++;
        if (mem_re !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 4'h3 || cpu_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL cpu_read_acc: got re=%b we=%b addr=%h ack=%b, want 1 0 3 0", mem_re, mem_we, mem_addr, cpu_ack);
        end
        tests_run++;
        if (owner !== 2'b01 || cpu_wait !== 1'b1) begin
            tests_failed++;
            $display("FAIL cpu_read_owner: got owner=%b wait=%b, want 01 1", owner, cpu_wait);
        end
        tick();
        tests_run++;
        if (cpu_ack !== 1'b1 || cpu_rdata !== 8'hA5 || mem_re !== 1'b0 || cpu_wait !== 1'b0) begin
            tests_failed++;
            $display("FAIL cpu_read_ack: got ack=%b rdata=%h re=%b wait=%b, want 1 a5 0 0", cpu_ack, cpu_rdata, mem_re, cpu_wait);
        end
        cpu_req = 0;
        tick();
        tests_run++;
        if (cpu_ack !== 1'b0 || cpu_rdata !== 8'hA5) begin
            tests_failed++;
            $display("FAIL cpu_read_hold: got ack=%b rdata=%h, want 0 a5", cpu_ack, cpu_rdata);
        end
    endtask

    task automatic test_owner_change();
        cpu_req = 1; cpu_we = 1; cpu_addr = 4'h7; cpu_wdata = 8'h5C;
        tick();
        tests_run++;
        if (mem_we !== 1'b1 || mem_re !== 1'b0 || mem_addr !== 4'h7 || mem_wdata !== 8'h5C) begin
            tests_failed++;
            $display("FAIL cpu_write_acc: got we=%b re=%b addr=%h wd=%h, want 1 0 7 5c", mem_we, mem_re, mem_addr, mem_wdata);
        end
        tick();
        tests_run++;
        if (cpu_ack !== 1'b1 || cpu_rdata !== 8'hA5) begin
            tests_failed++;
            $display("FAIL cpu_write_ack: got ack=%b rdata=%h, want 1 a5", cpu_ack, cpu_rdata);
        end
        cpu_req = 0; cpu_we = 0;
        tick();
        ldr_req = 1; ldr_we = 0; ldr_addr = 4'h7;
        tick();
        tests_run++;
        if (mem_we !== 1'b0 || mem_re !== 1'b0 || owner !== 2'b10 || ldr_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL turn_cycle: got we=%b re=%b owner=%b ack=%b, want 0 0 10 0", mem_we, mem_re, owner, ldr_ack);
        end
        tick();
        tests_run++;
        if (mem_re !== 1'b1 || mem_addr !== 4'h7 || ldr_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL ldr_read_acc: got re=%b addr=%h ack=%b, want 1 7 0", mem_re, mem_addr, ldr_ack);
        end
        tick();
        tests_run++;
        if (ldr_ack !== 1'b1 || ldr_rdata !== 8'h5C || cpu_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL ldr_read_ack: got lack=%b rdata=%h cack=%b, want 1 5c 0", ldr_ack, ldr_rdata, cpu_ack);
        end
        ldr_req = 0;
        tick();
    endtask

    task automatic test_fairness();
        logic [9:0] seq;
        int n = 0;
        int wait_err = 0;
        int excl_err = 0;
        seq = '0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 4'h3;
        ldr_req = 1; ldr_we = 0; ldr_addr = 4'h7;
        for (int c = 0; c < 60 && n < 10; c++) begin
            tick();
            if (cpu_ack && ldr_ack) excl_err++;
            if (mem_we && mem_re) excl_err++;
            if (cpu_wait !== ~cpu_ack) wait_err++;
            if (cpu_ack) begin seq[n] = 1'b0; n++; end
            else if (ldr_ack) begin seq[n] = 1'b1; n++; end
        end
        cpu_req = 0; ldr_req = 0;
        tests_run++;
        if (n != 10) begin
            tests_failed++;
            $display("FAIL fair_count: got %0d grants in budget, want 10", n);
        end
        tests_run++;
        if (seq !== 10'b0111101111) begin
            tests_failed++;
            $display("FAIL fair_sequence: got %b (bit0 first, 1=L), want 0111101111", seq);
        end
        tests_run++;
        if (wait_err != 0 || excl_err != 0) begin
            tests_failed++;
            $display("FAIL fair_wait_excl: got wait_err=%0d excl_err=%0d, want 0 0", wait_err, excl_err);
        end
        tests_run++;
        if (cpu_rdata !== 8'hA5 || ldr_rdata !== 8'h5C) begin
            tests_failed++;
            $display("FAIL fair_rdata: got c=%h l=%h, want a5 5c", cpu_rdata, ldr_rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int ack_err = 0;
        ldr_req = 1; ldr_we = 1; ldr_addr = 4'h9; ldr_wdata = 8'h3C;
        tick();
        tick();
        tests_run++;
        if (mem_we !== 1'b1 || mem_addr !== 4'h9) begin
            tests_failed++;
            $display("FAIL midrst_acc: got we=%b addr=%h, want 1 9", mem_we, mem_addr);
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({owner, mem_we, mem_re, mem_addr, mem_wdata, cpu_ack, ldr_ack, cpu_rdata, ldr_rdata} !== 36'h0) begin
            tests_failed++;
            $display("FAIL midrst_outputs: got owner=%b we=%b re=%b addr=%h wd=%h cack=%b lack=%b crd=%h lrd=%h, want all 0",
                     owner, mem_we, mem_re, mem_addr, mem_wdata, cpu_ack, ldr_ack, cpu_rdata, ldr_rdata);
        end
        ldr_req = 0; ldr_we = 0;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (ldr_ack !== 1'b0) ack_err++;
        end
        tests_run++;
        if (ack_err != 0) begin
            tests_failed++;
            $display("FAIL midrst_no_ack: got %0d ldr_ack cycles, want 0", ack_err);
        end
        cpu_req = 1; cpu_we = 0; cpu_addr = 4'h9;
        tick();
        tests_run++;
        if (mem_re !== 1'b1 || owner !== 2'b01) begin
            tests_failed++;
            $display("FAIL midrst_cpu_acc: got re=%b owner=%b, want 1 01", mem_re, owner);
        end
        tick();
        tests_run++;
        if (cpu_ack !== 1'b1 || cpu_rdata !== 8'h11) begin
            tests_failed++;
            $display("FAIL midrst_cpu_ack: got ack=%b rdata=%h, want 1 11", cpu_ack, cpu_rdata);
        end
        cpu_req = 0;
        tick();
    endtask

    task automatic test_lock();
        logic [10:0] seq;
        logic [10:0] exp;
        int n = 0;
        seq = '0;
`ifdef ARB_LOCK_EN
        exp = 11'b01111111111;
`else
        exp = 11'b10111101111;
`endif
        ldr_lock = 1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 4'h3;
        ldr_req = 1; ldr_we = 0; ldr_addr = 4'h7;
        for (int c = 0; c < 120 && n < 11; c++) begin
            tick();
            if (cpu_ack) begin seq[n] = 1'b0; n++; end
            else if (ldr_ack) begin seq[n] = 1'b1; n++; end
            if (n == 10) ldr_lock = 0;
        end
        cpu_req = 0; ldr_req = 0; ldr_lock = 0;
        tests_run++;
        if (n != 11) begin
            tests_failed++;
            $display("FAIL lock_count: got %0d grants in budget, want 11", n);
        end
        tests_run++;
        if (seq !== exp) begin
            tests_failed++;
            $display("FAIL lock_sequence: got %b (bit0 first, 1=L), want %b", seq, exp);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_owner_change();
        test_fairness();
        test_reset_mid();
        test_lock();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
